// File: rtl/if_id_skid.sv
// ----------------------------------------------------------------------------
// if_id_skid
//
// IF/ID pipeline register with a valid/ready handshake. Fetch presents an
// entry (instruction, current PC, next PC); decode consumes it. An output
// register plus one skid register let in_ready be derived purely from state,
// so decode back-pressure never reaches fetch combinationally.
//
// While no valid entry is held, the output shows the bubble values
// NOP_INST / RESET_PC / RESET_PC + INST_STEP.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active-low
//   in_valid       fetch presents an entry
//   in_ready       stage can accept (low only when the skid register is full)
//   in_inst        fetched instruction
//   in_cur_addr    PC of in_inst
//   in_next_addr   next PC of in_inst
//   flush          synchronous squash of all held entries
//   out_valid      decode-side entry valid
//   out_ready      decode accepts
//   out_inst       instruction to decode
//   out_cur_addr   PC to decode
//   out_next_addr  next PC to decode
//
// Optional build macro IF_ID_PERF_EN adds:
//   perf_stall_cnt cycles with out_valid & !out_ready (saturating)
//   perf_flush_cnt cycles with flush asserted (saturating)
// ----------------------------------------------------------------------------
module if_id_skid #(
    parameter int unsigned INST_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] NOP_INST  = 32'h0000_0000,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned INST_STEP = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_cur_addr,
    input  logic [ADDR_W-1:0] in_next_addr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_cur_addr,
    output logic [ADDR_W-1:0] out_next_addr
`ifdef IF_ID_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    // Bubble values, computed at ADDR_W so the next-PC wraps modulo 2^ADDR_W
    localparam logic [INST_W-1:0] BUB_INST = INST_W'(NOP_INST);
    localparam logic [ADDR_W-1:0] BUB_CUR  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] BUB_NEXT = ADDR_W'(RESET_PC) + ADDR_W'(INST_STEP);

    generate
        if (INST_W == 0 || ADDR_W == 0 || CNT_W == 0) begin : g_bad_cfg
            $error("if_id_skid: INST_W, ADDR_W and CNT_W must be non-zero");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [INST_W-1:0] skid_inst;
    logic [ADDR_W-1:0] skid_cur_addr;
    logic [ADDR_W-1:0] skid_next_addr;
    logic              in_fire;
    logic              out_fire;

    // Both handshake outputs decode only the state register
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= EMPTY;
            out_inst       <= BUB_INST;
            out_cur_addr   <= BUB_CUR;
            out_next_addr  <= BUB_NEXT;
            skid_inst      <= BUB_INST;
            skid_cur_addr  <= BUB_CUR;
            skid_next_addr <= BUB_NEXT;
        end else if (flush) begin
            // Flush overrides every transition; a same-cycle in_fire is dropped
            state          <= EMPTY;
            out_inst       <= BUB_INST;
            out_cur_addr   <= BUB_CUR;
            out_next_addr  <= BUB_NEXT;
            skid_inst      <= BUB_INST;
            skid_cur_addr  <= BUB_CUR;
            skid_next_addr <= BUB_NEXT;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state         <= ONE;
                        out_inst      <= in_inst;
                        out_cur_addr  <= in_cur_addr;
                        out_next_addr <= in_next_addr;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_inst      <= in_inst;
                        out_cur_addr  <= in_cur_addr;
                        out_next_addr <= in_next_addr;
                    end else if (in_fire) begin
                        // Decode stalled: park the new entry behind OUT
                        state          <= FULL;
                        skid_inst      <= in_inst;
                        skid_cur_addr  <= in_cur_addr;
                        skid_next_addr <= in_next_addr;
                    end else if (out_fire) begin
                        state         <= EMPTY;
                        out_inst      <= BUB_INST;
                        out_cur_addr  <= BUB_CUR;
                        out_next_addr <= BUB_NEXT;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state          <= ONE;
                        out_inst       <= skid_inst;
                        out_cur_addr   <= skid_cur_addr;
                        out_next_addr  <= skid_next_addr;
                        skid_inst      <= BUB_INST;
                        skid_cur_addr  <= BUB_CUR;
                        skid_next_addr <= BUB_NEXT;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef IF_ID_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_cur_addr;
    logic [31:0] in_next_addr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_cur_addr;
    logic [31:0] out_next_addr;
`ifdef IF_ID_PERF_EN
    logic [3:0]  perf_stall_cnt;
    logic [3:0]  perf_flush_cnt;
`endif

    // Second instance: 16-bit PC with a reset PC that wraps on +INST_STEP
    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_inst;
    logic [15:0] w_out_cur_addr;
    logic [15:0] w_out_next_addr;
    logic [15:0] w_in_cur_addr;
    logic [15:0] w_in_next_addr;
    logic        w_in_valid;
`ifdef IF_ID_PERF_EN
    logic [15:0] w_perf_stall_cnt;
    logic [15:0] w_perf_flush_cnt;
`endif

    int checks;
    int errors;

    if_id_skid #(
        .INST_W   (32),
        .ADDR_W   (32),
        .NOP_INST (32'h0000_0000),
        .RESET_PC (32'h0000_0000),
        .INST_STEP(4),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_cur_addr  (in_cur_addr),
        .in_next_addr (in_next_addr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_cur_addr (out_cur_addr),
        .out_next_addr(out_next_addr)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    if_id_skid #(
        .INST_W   (32),
        .ADDR_W   (16),
        .NOP_INST (32'h0000_0013),
        .RESET_PC (32'h0000_FFFE),
        .INST_STEP(4),
        .CNT_W    (16)
    ) dut_w (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (w_in_valid),
        .in_ready     (w_in_ready),
        .in_inst      (in_inst),
        .in_cur_addr  (w_in_cur_addr),
        .in_next_addr (w_in_next_addr),
        .flush        (flush),
        .out_valid    (w_out_valid),
        .out_ready    (out_ready),
        .out_inst     (w_out_inst),
        .out_cur_addr (w_out_cur_addr),
        .out_next_addr(w_out_next_addr)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cnt(w_perf_stall_cnt),
        .perf_flush_cnt(w_perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst);
        in_valid     = v;
        in_inst      = inst;
        in_cur_addr  = 32'h1000 + {inst[29:0], 2'b00};
        in_next_addr = 32'h1004 + {inst[29:0], 2'b00};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_inst = '0; in_cur_addr = '0; in_next_addr = '0;
        flush = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_cur_addr = '0; w_in_next_addr = '0;
        do_reset();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_hs: out_valid/in_ready got %b want 01", {out_valid, in_ready});
        end
        checks++;
        if (out_inst !== 32'h0 || out_cur_addr !== 32'h0 || out_next_addr !== 32'h4) begin
            errors++;
            $display("FAIL reset_bubble: got %h/%h/%h want 00000000/00000000/00000004",
                     out_inst, out_cur_addr, out_next_addr);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_inst !== vals[i] ||
                out_cur_addr !== 32'h1000 + (vals[i] << 2) ||
                out_next_addr !== 32'h1004 + (vals[i] << 2)) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b inst=%h cur=%h next=%h want inst %h",
                         i, out_valid, out_inst, out_cur_addr, out_next_addr, vals[i]);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready_%0d: in_ready got %b want 1", i, in_ready);
            end
        end
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_cur_addr !== 32'h0 ||
            out_next_addr !== 32'h4) begin
            errors++;
            $display("FAIL stream_drain: valid=%b %h/%h/%h want 0 bubble",
                     out_valid, out_inst, out_cur_addr, out_next_addr);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h11);
        tick();
        drive(1'b1, 32'h22);
        tick();
        drive(1'b0, 32'h0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h11) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b valid=%b inst=%h want 0 1 00000011",
                     in_ready, out_valid, out_inst);
        end
        // Held stable while stalled
        tick();
        checks++;
        if (out_inst !== 32'h11 || out_cur_addr !== 32'h1044 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: inst=%h cur=%h in_ready=%b want 00000011 00001044 0",
                     out_inst, out_cur_addr, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h22 || out_next_addr !== 32'h108c ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain1: valid=%b inst=%h next=%h in_ready=%b want 1 00000022 0000108c 1",
                     out_valid, out_inst, out_next_addr, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0) begin
            errors++;
            $display("FAIL bp_drain2: valid=%b inst=%h want 0 00000000", out_valid, out_inst);
        end
    endtask

    task automatic test_flush();
        logic seen33;
        seen33 = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h44);
        tick();
        drive(1'b1, 32'h55);
        tick();
        // FULL now; flush with a new entry on the input
        drive(1'b1, 32'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0 ||
            out_cur_addr !== 32'h0 || out_next_addr !== 32'h4) begin
            errors++;
            $display("FAIL flush_full: valid=%b in_ready=%b %h/%h/%h want 0 1 bubble",
                     out_valid, in_ready, out_inst, out_cur_addr, out_next_addr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid === 1'b1 || out_inst === 32'h33 || out_inst === 32'h55) seen33 = 1'b1;
        end
        checks++;
        if (seen33 !== 1'b0) begin
            errors++;
            $display("FAIL flush_leak: squashed entry reached output (got 1 want 0)");
        end
        // Flush in ONE with an accepted input: input must be discarded
        out_ready = 1'b0;
        drive(1'b1, 32'h66);
        tick();
        drive(1'b1, 32'h77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0) begin
            errors++;
            $display("FAIL flush_one: valid=%b inst=%h want 0 00000000", out_valid, out_inst);
        end
    endtask

    task automatic test_param_sweep();
        checks++;
        if (w_out_valid !== 1'b0 || w_out_inst !== 32'h13 || w_out_cur_addr !== 16'hFFFE ||
            w_out_next_addr !== 16'h0002) begin
            errors++;
            $display("FAIL wrap_bubble: valid=%b %h/%h/%h want 0 00000013/fffe/0002",
                     w_out_valid, w_out_inst, w_out_cur_addr, w_out_next_addr);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h99);
        tick();
        drive(1'b1, 32'hAA);
        tick();
        drive(1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0 ||
            out_cur_addr !== 32'h0 || out_next_addr !== 32'h4) begin
            errors++;
            $display("FAIL async_reset: valid=%b in_ready=%b %h/%h/%h want 0 1 bubble",
                     out_valid, in_ready, out_inst, out_cur_addr, out_next_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_lost: valid=%b inst=%h want 0 00000000", out_valid, out_inst);
        end
    endtask

`ifdef IF_ID_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (perf_stall_cnt !== 4'd0 || perf_flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL perf_reset: stall=%0d flush=%0d want 0 0", perf_stall_cnt, perf_flush_cnt);
        end
        out_ready = 1'b0;
        drive(1'b1, 32'h5);
        tick();
        drive(1'b0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (perf_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL perf_stall: got %0d want 15", perf_stall_cnt);
        end
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (perf_flush_cnt !== 4'd2) begin
            errors++;
            $display("FAIL perf_flush: got %0d want 2", perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_param_sweep();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_async_reset();
`ifdef IF_ID_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got timeout want finish)");
        $fatal(1, "timeout");
    end

endmodule
